// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter sharing the single-port data memory
//
// Port 0 is the CPU load/store path, port 1 the memory-init/DMA loader.
// At most one word access is granted per cycle, and the response is
// registered one cycle after the accept.
//
// Ports:
//   clk, reset                  clock; asynchronous active-low reset
//   reqN_valid/we/addr/wdata    request from port N (held until reqN_ready)
//   reqN_ready                  combinational grant/accept for port N
//   rspN_valid/rdata/err        registered response pulse for port N
//   mem_addr/din/read/write     drive to the single-port memory
//   mem_dout                    asynchronous read data from memory
module dmem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int MEM_DEPTH = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam int              CW         = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]   BURST_MAX  = CW'(MAX_BURST);
    // 34-bit limit so 4*MEM_DEPTH cannot wrap against a 32-bit address.
    localparam logic [33:0]     ADDR_LIMIT = 34'(4 * MEM_DEPTH);

    logic [1:0]    state;
    logic [CW-1:0] beat_cnt;
    logic          rr_last;

    logic          grant_any;
    logic          grant_port;
    logic          accept;
    logic          sel_we;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          sel_err;
    logic          good_read;
    logic          same_owner;

    // Owner keeps the memory while under its burst budget, or indefinitely
    // when the other port has nothing to do; otherwise round-robin decides.
    always_comb begin
        grant_any  = 1'b0;
        grant_port = 1'b0;
        if (state == ST_OWN0 && req0_valid && (beat_cnt < BURST_MAX || !req1_valid)) begin
            grant_any  = 1'b1;
            grant_port = 1'b0;
        end else if (state == ST_OWN1 && req1_valid && (beat_cnt < BURST_MAX || !req0_valid)) begin
            grant_any  = 1'b1;
            grant_port = 1'b1;
        end else if (req0_valid && req1_valid) begin
            grant_any  = 1'b1;
            grant_port = ~rr_last;
        end else if (req0_valid) begin
            grant_any  = 1'b1;
            grant_port = 1'b0;
        end else if (req1_valid) begin
            grant_any  = 1'b1;
            grant_port = 1'b1;
        end
    end

    // Gating with reset makes every combinational output drop the moment
    // reset asserts, not at the next edge.
    assign accept     = grant_any & reset;
    assign req0_ready = accept & ~grant_port;
    assign req1_ready = accept &  grant_port;

    assign sel_we    = grant_port ? req1_we    : req0_we;
    assign sel_addr  = grant_port ? req1_addr  : req0_addr;
    assign sel_wdata = grant_port ? req1_wdata : req0_wdata;
    assign sel_err   = (sel_addr[1:0] != 2'b00) | ({2'b00, sel_addr} >= ADDR_LIMIT);
    assign good_read = accept & ~sel_we & ~sel_err;

    assign mem_addr  = accept ? sel_addr  : 32'h0;
    assign mem_din   = accept ? sel_wdata : 32'h0;
    assign mem_write = accept &  sel_we & ~sel_err;
    assign mem_read  = good_read;

    assign same_owner = (state == ST_OWN0 && !grant_port) || (state == ST_OWN1 && grant_port);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            rr_last    <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= 32'h0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= 32'h0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= req0_ready;
            rsp0_err   <= req0_ready & sel_err;
            rsp0_rdata <= (req0_ready && good_read) ? mem_dout : 32'h0;
            rsp1_valid <= req1_ready;
            rsp1_err   <= req1_ready & sel_err;
            rsp1_rdata <= (req1_ready && good_read) ? mem_dout : 32'h0;

            if (accept) begin
                rr_last <= grant_port;
                if (same_owner) begin
                    if (beat_cnt != BURST_MAX) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end else begin
                    state    <= grant_port ? ST_OWN1 : ST_OWN0;
                    beat_cnt <= CW'(1);
                end
            end else begin
                state    <= ST_IDLE;
                beat_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_we;
    logic [31:0] req0_addr, req0_wdata;
    logic        rsp0_valid, rsp0_err;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_read, mem_write;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:16383];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[15:2]] <= mem_din;
    end
    assign mem_dout = mem[mem_addr[15:2]];

    dmem_arbiter #(.MAX_BURST(4), .MEM_DEPTH(16384)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
        .mem_write(mem_write), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic exp_seq [0:9];

    initial begin
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        reset = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;

        // Reset state, with a request present that must not be granted.
        #2;
        req0_valid = 1'b1; req0_addr = 32'h100;
        #1;
        chk("rst_ready0", {31'h0, req0_ready}, 32'h0);
        chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
        chk("rst_rsp0_valid", {31'h0, rsp0_valid}, 32'h0);
        chk("rst_rsp1_valid", {31'h0, rsp1_valid}, 32'h0);
        req0_valid = 1'b0;
        @(negedge clk); reset = 1'b1;

        // Test 1: port0 write then read back.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h100; req0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_wr_ready0", {31'h0, req0_ready}, 32'h1);
        chk("t1_wr_ready1", {31'h0, req1_ready}, 32'h0);
        chk("t1_mem_write", {31'h0, mem_write}, 32'h1);
        chk("t1_mem_read", {31'h0, mem_read}, 32'h0);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_din", mem_din, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("t1_wr_rsp_valid", {31'h0, rsp0_valid}, 32'h1);
        chk("t1_wr_rsp_err", {31'h0, rsp0_err}, 32'h0);
        chk("t1_wr_rsp_rdata", rsp0_rdata, 32'h0);
        req0_we = 1'b0;
        @(negedge clk);
        chk("t1_rd_mem_read", {31'h0, mem_read}, 32'h1);
        chk("t1_rd_mem_write", {31'h0, mem_write}, 32'h0);
        @(posedge clk); #1;
        chk("t1_rd_rsp_valid", {31'h0, rsp0_valid}, 32'h1);
        chk("t1_rd_rdata", rsp0_rdata, 32'hDEADBEEF);
        chk("t1_rd_err", {31'h0, rsp0_err}, 32'h0);
        chk("t1_rsp1_quiet", {31'h0, rsp1_valid}, 32'h0);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_idle_ready0", {31'h0, req0_ready}, 32'h0);
        @(posedge clk); #1;
        chk("t1_idle_rsp0", {31'h0, rsp0_valid}, 32'h0);

        // Test 4: out-of-range and misaligned reads on port1, then a legal read.
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h00010000;
        @(negedge clk);
        chk("t4_oor_ready1", {31'h0, req1_ready}, 32'h1);
        chk("t4_oor_mem_read", {31'h0, mem_read}, 32'h0);
        chk("t4_oor_mem_write", {31'h0, mem_write}, 32'h0);
        @(posedge clk); #1;
        chk("t4_oor_rsp_valid", {31'h0, rsp1_valid}, 32'h1);
        chk("t4_oor_err", {31'h0, rsp1_err}, 32'h1);
        chk("t4_oor_rdata", rsp1_rdata, 32'h0);
        req1_addr = 32'h102;
        @(negedge clk);
        chk("t4_mis_mem_read", {31'h0, mem_read}, 32'h0);
        @(posedge clk); #1;
        chk("t4_mis_err", {31'h0, rsp1_err}, 32'h1);
        chk("t4_mis_rdata", rsp1_rdata, 32'h0);
        req1_addr = 32'h100;
        @(negedge clk);
        chk("t4_ok_mem_read", {31'h0, mem_read}, 32'h1);
        @(posedge clk); #1;
        chk("t4_ok_err", {31'h0, rsp1_err}, 32'h0);
        chk("t4_ok_rdata", rsp1_rdata, 32'hDEADBEEF);
        req1_valid = 1'b0;
        @(posedge clk); #1;

        // Test 5: reset asserted in the middle of a port0 write accept.
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h200; req0_wdata = 32'h12345678;
        @(negedge clk);
        chk("t5_pre_mem_write", {31'h0, mem_write}, 32'h1);
        #1; reset = 1'b0; #1;
        chk("t5_mem_write_drop", {31'h0, mem_write}, 32'h0);
        chk("t5_ready0_drop", {31'h0, req0_ready}, 32'h0);
        chk("t5_mem_addr_drop", mem_addr, 32'h0);
        @(posedge clk); #1;
        chk("t5_no_rsp0", {31'h0, rsp0_valid}, 32'h0);
        req0_we = 1'b0; req0_addr = 32'h100;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h100;
        @(negedge clk); reset = 1'b1; #1;

        // Test 2: both ports valid from reset release.
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t2_ready0_%0d", i), {31'h0, req0_ready}, {31'h0, ~exp_seq[i]});
            chk($sformatf("t2_ready1_%0d", i), {31'h0, req1_ready}, {31'h0, exp_seq[i]});
            @(posedge clk); #1;
            chk($sformatf("t2_rsp0_%0d", i), {31'h0, rsp0_valid}, {31'h0, ~exp_seq[i]});
            chk($sformatf("t2_rsp1_%0d", i), {31'h0, rsp1_valid}, {31'h0, exp_seq[i]});
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        // Test 3: port1 alone for 10 beats, then port0 arrives with count saturated.
        req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t3_ready1_%0d", i), {31'h0, req1_ready}, 32'h1);
            chk($sformatf("t3_ready0_%0d", i), {31'h0, req0_ready}, 32'h0);
            @(posedge clk); #1;
            chk($sformatf("t3_rdata1_%0d", i), rsp1_rdata, 32'hDEADBEEF);
        end
        req0_valid = 1'b1;
        @(negedge clk);
        chk("t3_switch_ready0", {31'h0, req0_ready}, 32'h1);
        chk("t3_switch_ready1", {31'h0, req1_ready}, 32'h0);
        @(posedge clk); #1;
        chk("t3_switch_rsp0", {31'h0, rsp0_valid}, 32'h1);
        chk("t3_switch_rsp1", {31'h0, rsp1_valid}, 32'h0);
        chk("t3_switch_rdata0", rsp0_rdata, 32'hDEADBEEF);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
